// File: rtl/dht11_sensor_model_pkg.sv
//------------------------------------------------------------------------------
// dht11_sensor_model_pkg
//   Shared DHT11 frame width, FSM state encoding and frame builder.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dht11_sensor_model_pkg;

   localparam int FRAME_W = 40;
   localparam int US_W    = 16;
   localparam int IDX_W   = 6;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE     = 4'd0;
   localparam state_t S_HOST_LOW = 4'd1;
   localparam state_t S_RSP_WAIT = 4'd2;
   localparam state_t S_RSP_LOW  = 4'd3;
   localparam state_t S_RSP_HIGH = 4'd4;
   localparam state_t S_BIT_LOW  = 4'd5;
   localparam state_t S_BIT_HIGH = 4'd6;
   localparam state_t S_END_LOW  = 4'd7;

   // Parity is the 8-bit wrapped byte sum; bit 0 flipped for error injection.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic [7:0] humi_int,
      input logic [7:0] humi_dec,
      input logic [7:0] temp_int,
      input logic [7:0] temp_dec,
      input logic       parity_err
   );
      logic [7:0] parity;
      parity = humi_int + humi_dec + temp_int + temp_dec;
      parity = parity ^ {7'd0, parity_err};
      return {humi_int, humi_dec, temp_int, temp_dec, parity};
   endfunction

endpackage

`default_nettype wire

// File: rtl/dht11_sensor_model_us_timer.sv
//------------------------------------------------------------------------------
// dht11_sensor_model_us_timer
//   Microsecond prescaler plus saturating microsecond counter with sync clear.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dht11_sensor_model_us_timer #(
   parameter int PRESCALE = 100,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   output logic             o_tick,
   output logic [CNT_W-1:0] o_us_cnt
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] us_cnt;

   // o_tick marks the last clock of each microsecond.
   assign o_tick   = (pre_cnt == PRE_W'(PRESCALE - 1));
   assign o_us_cnt = us_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt <= '0;
         us_cnt  <= '0;
      end else if (i_clear) begin
         pre_cnt <= '0;
         us_cnt  <= '0;
      end else if (o_tick) begin
         pre_cnt <= '0;
         if (us_cnt != '1)
            us_cnt <= us_cnt + 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dht11_sensor_model.sv
//------------------------------------------------------------------------------
// dht11_sensor_model
//   DHT11 responder: detects host start, sends presence and a 40-bit frame.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dht11_sensor_model
   import dht11_sensor_model_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int MIN_START_US = 18000,
   parameter int RSP_WAIT_US  = 30,
   parameter int RSP_LOW_US   = 80,
   parameter int RSP_HIGH_US  = 80,
   parameter int BIT_LOW_US   = 50,
   parameter int BIT0_HIGH_US = 27,
   parameter int BIT1_HIGH_US = 70
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_humi_int,
   input  logic [7:0] i_humi_dec,
   input  logic [7:0] i_temp_int,
   input  logic [7:0] i_temp_dec,
   input  logic       i_parity_err,
   inout  wire        io_dht,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_start_err
);

   localparam int PRESCALE = CLK_HZ / 1_000_000;

   logic [1:0]         sync_ff;
   logic               din_s;
   state_t             state;
   state_t             state_nxt;
   logic               tmr_clear;
   logic               tick;
   logic [US_W-1:0]    us_cnt;
   logic [US_W-1:0]    phase_last;
   logic               phase_end;
   logic [FRAME_W-1:0] shreg;
   logic [IDX_W-1:0]   bit_idx;
   logic               drive_low;
   logic               busy;
   logic               done_q;
   logic               start_err_q;

   // Idle level is high, so the synchroniser resets to 1 to avoid a false start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_ff <= 2'b11;
      else      sync_ff <= {sync_ff[0], io_dht};
   end
   assign din_s = sync_ff[1];

   // Counting already runs in the first low IDLE cycle so host low time is exact.
   assign tmr_clear = (state == S_IDLE) ? din_s : (state_nxt != state);

   dht11_sensor_model_us_timer #(
      .PRESCALE (PRESCALE),
      .CNT_W    (US_W)
   ) u_us_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (tmr_clear),
      .o_tick   (tick),
      .o_us_cnt (us_cnt)
   );

   always_comb begin
      phase_last = '0;
      case (state)
         S_RSP_WAIT: phase_last = US_W'(RSP_WAIT_US - 1);
         S_RSP_LOW:  phase_last = US_W'(RSP_LOW_US - 1);
         S_RSP_HIGH: phase_last = US_W'(RSP_HIGH_US - 1);
         S_BIT_LOW:  phase_last = US_W'(BIT_LOW_US - 1);
         S_BIT_HIGH: phase_last = shreg[FRAME_W-1] ? US_W'(BIT1_HIGH_US - 1)
                                                    : US_W'(BIT0_HIGH_US - 1);
         S_END_LOW:  phase_last = US_W'(BIT_LOW_US - 1);
         default:    phase_last = '0;
      endcase
   end
   assign phase_end = tick && (us_cnt == phase_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (!din_s) state_nxt = S_HOST_LOW;
         S_HOST_LOW: if (din_s)
                        state_nxt = (us_cnt >= US_W'(MIN_START_US)) ? S_RSP_WAIT : S_IDLE;
         S_RSP_WAIT: if (phase_end) state_nxt = S_RSP_LOW;
         S_RSP_LOW:  if (phase_end) state_nxt = S_RSP_HIGH;
         S_RSP_HIGH: if (phase_end) state_nxt = S_BIT_LOW;
         S_BIT_LOW:  if (phase_end) state_nxt = S_BIT_HIGH;
         S_BIT_HIGH: if (phase_end) state_nxt = (bit_idx == '0) ? S_END_LOW : S_BIT_LOW;
         S_END_LOW:  if (phase_end) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      drive_low = 1'b0;
      busy      = 1'b0;
      case (state)
         S_RSP_WAIT: busy = 1'b1;
         S_RSP_LOW:  begin busy = 1'b1; drive_low = 1'b1; end
         S_RSP_HIGH: busy = 1'b1;
         S_BIT_LOW:  begin busy = 1'b1; drive_low = 1'b1; end
         S_BIT_HIGH: busy = 1'b1;
         S_END_LOW:  begin busy = 1'b1; drive_low = 1'b1; end
         default:    begin busy = 1'b0; drive_low = 1'b0; end
      endcase
   end

   // Snapshot of the value ports is taken only when the start is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         bit_idx <= '0;
      end else if (state == S_HOST_LOW && state_nxt == S_RSP_WAIT) begin
         shreg   <= build_frame(i_humi_int, i_humi_dec, i_temp_int, i_temp_dec, i_parity_err);
         bit_idx <= IDX_W'(FRAME_W - 1);
      end else if (state == S_BIT_HIGH && state_nxt == S_BIT_LOW) begin
         shreg   <= shreg << 1;
         bit_idx <= bit_idx - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
      end else begin
         done_q      <= (state == S_END_LOW) && (state_nxt == S_IDLE);
         start_err_q <= (state == S_HOST_LOW) && (state_nxt == S_IDLE);
      end
   end

   assign io_dht      = drive_low ? 1'b0 : 1'bz;
   assign o_busy      = busy;
   assign o_done      = done_q;
   assign o_start_err = start_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dht11_sensor_model.sv
//------------------------------------------------------------------------------
// tb_dht11_sensor_model
//   Host-side bench: issues start pulses and decodes the returned frames.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dht11_sensor_model;

   localparam int CLK_HZ = 2_000_000;
   localparam int P      = CLK_HZ / 1_000_000;
   localparam int MIN_US = 200;
   localparam int HALF   = 250;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] humi_int = 8'h00;
   logic [7:0] humi_dec = 8'h00;
   logic [7:0] temp_int = 8'h00;
   logic [7:0] temp_dec = 8'h00;
   logic       parity_err = 1'b0;
   logic       host_low = 1'b0;
   logic       busy;
   logic       done;
   logic       start_err;
   wire        dht;

   int checks   = 0;
   int failures = 0;

   pullup (dht);
   assign dht = host_low ? 1'b0 : 1'bz;

   always #HALF clk = ~clk;

   dht11_sensor_model #(
      .CLK_HZ       (CLK_HZ),
      .MIN_START_US (MIN_US)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_humi_int   (humi_int),
      .i_humi_dec   (humi_dec),
      .i_temp_int   (temp_int),
      .i_temp_dec   (temp_dec),
      .i_parity_err (parity_err),
      .io_dht       (dht),
      .o_busy       (busy),
      .o_done       (done),
      .o_start_err  (start_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference frame straight from the protocol rules.
   function automatic logic [39:0] model(input logic [7:0] hi, hd, ti, td, input logic pe);
      int sum;
      logic [7:0] par;
      sum = int'(hi) + int'(hd) + int'(ti) + int'(td);
      par = 8'((sum % 256) ^ (pe ? 1 : 0));
      return {hi, hd, ti, td, par};
   endfunction

   task automatic run_len(input logic lvl, input int limit, output int n);
      n = 0;
      while (dht === lvl && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic host_start(input int us);
      @(negedge clk);
      host_low = 1'b1;
      repeat (us * P) @(negedge clk);
      host_low = 1'b0;
   endtask

   // Called right after host release; stops at the start of bit stop_at if < 40.
   task automatic receive_frame(input int stop_at, input logic [39:0] exp,
                                input string tag, output logic [39:0] got);
      int  n;
      int  bad_t;
      logic b;
      got   = '0;
      bad_t = 0;
      #1;
      run_len(1'b1, 200 * P, n);
      check({tag, "_rsp_delay_ok"}, (n >= 30 * P) && (n <= 30 * P + 4), 1);
      check({tag, "_busy"}, busy, 1'b1);
      run_len(1'b0, 200 * P, n);
      check({tag, "_rsp_low"}, n, 80 * P);
      run_len(1'b1, 200 * P, n);
      check({tag, "_rsp_high"}, n, 80 * P);
      for (int i = 0; i < 40; i++) begin
         if (i == stop_at) return;
         run_len(1'b0, 100 * P, n);
         if (n != 50 * P) bad_t++;
         run_len(1'b1, 100 * P, n);
         b   = (n > 48 * P);
         got = {got[38:0], b};
         if (n != (b ? 70 * P : 27 * P)) bad_t++;
      end
      check({tag, "_bit_timing_errs"}, bad_t, 0);
      check({tag, "_data"}, got, exp);
      run_len(1'b0, 100 * P, n);
      check({tag, "_end_low"}, n, 50 * P);
      check({tag, "_done_pulse"}, done, 1'b1);
      check({tag, "_busy_fall"}, busy, 1'b0);
      @(negedge clk);
      check({tag, "_done_single"}, done, 1'b0);
   endtask

   task automatic short_start(input int us, input string tag);
      int errs;
      int lows;
      int busys;
      errs  = 0;
      lows  = 0;
      busys = 0;
      host_start(us);
      #1;
      repeat (60 * P) begin
         if (start_err === 1'b1) errs++;
         if (dht !== 1'b1) lows++;
         if (busy !== 1'b0) busys++;
         @(negedge clk);
      end
      check({tag, "_start_err_pulses"}, errs, 1);
      check({tag, "_bus_low_samples"}, lows, 0);
      check({tag, "_busy_samples"}, busys, 0);
   endtask

   initial begin
      #(64'd140_000 * 2 * HALF);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] got;
      logic [39:0] exp;

      repeat (3) @(negedge clk);
      check("reset_bus", dht, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_start_err", start_err, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Nominal frame at the exact minimum start length.
      humi_int = 8'h37; humi_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
      host_start(MIN_US);
      receive_frame(40, 40'h37_00_19_05_55, "frame_a", got);

      short_start(MIN_US - 1, "short_min_m1");
      short_start(MIN_US / 2, "short_half");

      humi_int = 8'hFF; humi_dec = 8'hFF; temp_int = 8'hFF; temp_dec = 8'hFF;
      host_start(MIN_US);
      receive_frame(40, model(humi_int, humi_dec, temp_int, temp_dec, 1'b0), "frame_ff", got);
      check("ff_parity_byte", got[7:0], 8'hFC);

      parity_err = 1'b1;
      host_start(MIN_US);
      receive_frame(40, model(humi_int, humi_dec, temp_int, temp_dec, 1'b1), "frame_ffpe", got);
      check("ffpe_parity_byte", got[7:0], 8'hFD);
      check("ffpe_data_bytes", got[39:8], 32'hFFFF_FFFF);
      parity_err = 1'b0;

      // Reset asserted during bit 20 must free the bus immediately.
      host_start(MIN_US);
      receive_frame(20, 40'd0, "frame_abort", got);
      check("abort_bus_low_before", dht, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_bus_released", dht, 1'b1);
      check("abort_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      humi_int   = 8'($urandom);
      humi_dec   = 8'($urandom);
      temp_int   = 8'($urandom);
      temp_dec   = 8'($urandom);
      parity_err = 1'($urandom);
      exp = model(humi_int, humi_dec, temp_int, temp_dec, parity_err);
      host_start(MIN_US);
      receive_frame(40, exp, "frame_rand", got);
      parity_err = 1'b0;

      // Input change mid-frame is ignored until the next start.
      humi_int = 8'h37; humi_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
      exp = model(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      host_start(MIN_US);
      fork
         receive_frame(40, exp, "frame_chg1", got);
         begin
            repeat (1000 * P) @(negedge clk);
            temp_int = 8'h20;
         end
      join
      host_start(MIN_US);
      receive_frame(40, model(8'h37, 8'h00, 8'h20, 8'h05, 1'b0), "frame_chg2", got);
      check("chg2_temp_int", got[23:16], 8'h20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
